hgc_regfile: RTL and testbench

// - Host-facing register block for the MDA/Hercules adapter: ISA I/O decode, strobe sync, mode control,

---
 rtl/hgc_pkg.sv | 31 +++
 rtl/isa_strobe_sync.sv | 33 +++
 rtl/hgc_regfile.sv | 201 ++++++++++++++++++++
 tb/tb_hgc_regfile.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hgc_pkg.sv
// Shared constants for the MDA/Hercules host register block.
// No logic of its own; the register offsets, reset values and bit positions live here.
// No flow control; everything here is a compile-time constant or a pure function.
package hgc_pkg;

    // Register offsets inside the 16-byte I/O window. CRTC occupies +0..+7.
    localparam logic [3:0] OFS_CTRL  = 4'h8;
    localparam logic [3:0] OFS_LPSET = 4'h9;
    localparam logic [3:0] OFS_STAT  = 4'hA;
    localparam logic [3:0] OFS_LPCLR = 4'hB;
    localparam logic [3:0] OFS_CONF  = 4'hF;

    // Mode control comes up as text mode, blink and video enabled.
    localparam logic [7:0] CTRL_RESET = 8'h28;

    // Mode control bit positions.
    localparam int CTRL_PAGE_BIT  = 7;
    localparam int CTRL_BLINK_BIT = 5;
    localparam int CTRL_VIDEO_BIT = 3;
    localparam int CTRL_GRPH_BIT  = 1;

    // Status bits 6..4 always read as ones on real MDA hardware.
    localparam logic [2:0] STAT_ONES = 3'b111;

    function automatic logic [7:0] stat_byte(input logic vsync_l, input logic video,
                                             input logic sw, input logic latch,
                                             input logic hsync);
        return {vsync_l, STAT_ONES, video, sw, latch, hsync};
    endfunction

endpackage

// File: rtl/isa_strobe_sync.sv
// Synchronises one active-low ISA strobe and flags its falling edge.
// Latency: sync_l lags the pin by SYNC_STAGES clk; fall_p is high for one clk after that.
// No backpressure: a strobe held low fires once and never again until released.
//   clk, reset_l : clock, async active-low reset (flops reset to the inactive/high level)
//   raw_l        : asynchronous strobe pin
//   sync_l       : synchronised level;  fall_p : one-cycle falling-edge pulse
module isa_strobe_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_l,
    input  logic raw_l,
    output logic sync_l,
    output logic fall_p
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   last_q;

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            sync_q <= '1;
            last_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_l};
            last_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_l = sync_q[SYNC_STAGES-1];
    assign fall_p = last_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/hgc_regfile.sv
// Host register block for the MDA/Hercules adapter: I/O decode, mode/config regs, status, blink.
// Latency: reads are combinational from the raw pins; writes land SYNC_STAGES+1 clk after iow_l falls.
// No backpressure: the ISA bus cannot be stalled; a held strobe produces exactly one write.
//   ISA side : bus_a, bus_aen, bus_ior_l/iow_l/memr_l/memw_l, bus_d in; bus_out, bus_dir out
//   CRTC/VRAM: crtc_cs/wr/rd, mem_cs/wr/rd out; crtc_rdata, vram_rdata in
//   Video    : hsync_in, vsync_l_in, video_in in; grph_mode, grph_page, video_enabled,
//              blink_enabled, cursor_blink, char_blink out
//   Lightpen : lpen_in, lpen_sw in; lpen_strobe out (active only with LIGHTPEN_EN defined)
module hgc_regfile
    import hgc_pkg::*;
#(
    parameter logic [19:0] IO_BASE      = 20'h003B0,
    parameter logic [3:0]  MEM_SEG      = 4'hB,
    parameter bit          HGC_EN       = 1'b1,
    parameter int          SYNC_STAGES  = 2,
    parameter int          BLINK_FRAMES = 8
) (
    input  logic        clk,
    input  logic        reset_l,
    input  logic [19:0] bus_a,
    input  logic        bus_aen,
    input  logic        bus_ior_l,
    input  logic        bus_iow_l,
    input  logic        bus_memr_l,
    input  logic        bus_memw_l,
    input  logic [7:0]  bus_d,
    output logic [7:0]  bus_out,
    output logic        bus_dir,
    input  logic [7:0]  crtc_rdata,
    input  logic [7:0]  vram_rdata,
    output logic        crtc_cs,
    output logic        crtc_wr,
    output logic        crtc_rd,
    output logic        mem_cs,
    output logic        mem_wr,
    output logic        mem_rd,
    input  logic        hsync_in,
    input  logic        vsync_l_in,
    input  logic        video_in,
    input  logic        lpen_in,
    input  logic        lpen_sw,
    output logic        lpen_strobe,
    output logic        grph_mode,
    output logic        grph_page,
    output logic        video_enabled,
    output logic        blink_enabled,
    output logic        cursor_blink,
    output logic        char_blink
);

    localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CW-1:0] FRAME_LAST = CW'(BLINK_FRAMES - 1);

    // ---------------- strobe synchronisers ----------------
    logic ior_sync_l, ior_fall, iow_sync_l, iow_fall;
    logic memr_sync_l, memr_fall, memw_sync_l, memw_fall;
    logic vs_sync_l, vs_fall;

    isa_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ior  (.clk(clk), .reset_l(reset_l),
        .raw_l(bus_ior_l),  .sync_l(ior_sync_l),  .fall_p(ior_fall));
    isa_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_iow  (.clk(clk), .reset_l(reset_l),
        .raw_l(bus_iow_l),  .sync_l(iow_sync_l),  .fall_p(iow_fall));
    isa_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_memr (.clk(clk), .reset_l(reset_l),
        .raw_l(bus_memr_l), .sync_l(memr_sync_l), .fall_p(memr_fall));
    isa_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_memw (.clk(clk), .reset_l(reset_l),
        .raw_l(bus_memw_l), .sync_l(memw_sync_l), .fall_p(memw_fall));
    // vsync is active-low at the pin, so its falling edge is the start of vertical retrace.
    isa_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_vs   (.clk(clk), .reset_l(reset_l),
        .raw_l(vsync_l_in), .sync_l(vs_sync_l),   .fall_p(vs_fall));

    logic unused_sync;
    assign unused_sync = ^{ior_sync_l, iow_sync_l, memr_fall, memw_fall, vs_sync_l};

    // ---------------- address decode ----------------
    logic [7:0] ctrl_q, ctrl_d;
    logic [1:0] conf_q, conf_d;
    logic       io_win;
    logic       ctrl_sel, lpset_sel, stat_sel, lpclr_sel, conf_sel;

    assign io_win    = ~bus_aen & (bus_a[19:4] == IO_BASE[19:4]);
    assign crtc_cs   = ~bus_aen & (bus_a[19:3] == IO_BASE[19:3]);
    assign ctrl_sel  = io_win & (bus_a[3:0] == OFS_CTRL);
    assign lpset_sel = io_win & (bus_a[3:0] == OFS_LPSET);
    assign stat_sel  = io_win & (bus_a[3:0] == OFS_STAT);
    assign lpclr_sel = io_win & (bus_a[3:0] == OFS_LPCLR);
    assign conf_sel  = io_win & (bus_a[3:0] == OFS_CONF);

    assign grph_page     = ctrl_q[CTRL_PAGE_BIT] & HGC_EN;
    assign blink_enabled = ctrl_q[CTRL_BLINK_BIT];
    assign video_enabled = ctrl_q[CTRL_VIDEO_BIT];
    assign grph_mode     = ctrl_q[CTRL_GRPH_BIT];

    assign mem_cs  = (bus_a[19:15] == {MEM_SEG, grph_page});
    assign mem_wr  = ~memw_sync_l & mem_cs;
    assign mem_rd  = ~memr_sync_l & mem_cs;
    assign crtc_wr = iow_fall & crtc_cs;
    assign crtc_rd = ior_fall & crtc_cs;

    // ---------------- light pen ----------------
    logic stat_sw, stat_latch;
`ifdef LIGHTPEN_EN
    logic lpen_rise, lpen_sync_l, lpen_latch_q, lpen_latch_d;
    logic unused_lpen;

    // Inverting the pin turns the pen's rising edge into the synchroniser's falling edge.
    isa_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_lpen (.clk(clk), .reset_l(reset_l),
        .raw_l(~lpen_in), .sync_l(lpen_sync_l), .fall_p(lpen_rise));
    assign unused_lpen = lpen_sync_l;

    always_comb begin
        lpen_latch_d = lpen_latch_q;
        if (iow_fall && lpclr_sel) begin
            lpen_latch_d = 1'b0;    // clear beats a coincident pen edge
        end else if ((iow_fall && lpset_sel) || lpen_rise) begin
            lpen_latch_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) lpen_latch_q <= 1'b0;
        else          lpen_latch_q <= lpen_latch_d;
    end

    // Only the first pen hit after a clear triggers a CRTC capture.
    assign lpen_strobe = lpen_rise & ~lpen_latch_q;
    assign stat_sw     = lpen_sw;
    assign stat_latch  = lpen_latch_q;
`else
    logic unused_lpen;
    assign unused_lpen = ^{lpen_in, lpen_sw, lpset_sel, lpclr_sel};
    assign lpen_strobe = 1'b0;
    assign stat_sw     = 1'b0;
    assign stat_latch  = 1'b0;
`endif

    // ---------------- read path (combinational from raw pins) ----------------
    logic mem_rd_raw, stat_rd_raw, crtc_rd_raw;
    assign mem_rd_raw  = mem_cs & ~bus_memr_l;
    assign stat_rd_raw = stat_sel & ~bus_ior_l;
    assign crtc_rd_raw = crtc_cs & bus_a[0] & ~bus_ior_l;

    always_comb begin
        bus_out = 8'h00;
        if (mem_rd_raw)       bus_out = vram_rdata;
        else if (stat_rd_raw) bus_out = stat_byte(vsync_l_in, video_in, stat_sw,
                                                  stat_latch, hsync_in);
        else if (crtc_rd_raw) bus_out = crtc_rdata;
    end

    assign bus_dir = ((crtc_cs | stat_sel) & ~bus_ior_l) | (mem_cs & ~bus_memr_l);

    // ---------------- control, config and blink state ----------------
    logic [CW-1:0] frame_q, frame_d;
    logic          cursor_q, cursor_d, char_q, char_d;

    always_comb begin
        ctrl_d   = ctrl_q;
        conf_d   = conf_q;
        frame_d  = frame_q;
        cursor_d = cursor_q;
        char_d   = char_q;
        if (iow_fall && ctrl_sel) begin
            // Graphics mode and the second page need the matching config bit unlocked.
            ctrl_d = {bus_d[7] & conf_q[1] & HGC_EN, bus_d[6:2],
                      bus_d[1] & conf_q[0] & HGC_EN, bus_d[0]};
        end
        if (iow_fall && conf_sel && HGC_EN) begin
            conf_d = bus_d[1:0];
        end
        if (vs_fall) begin
            if (frame_q == FRAME_LAST) begin
                frame_d  = '0;
                cursor_d = ~cursor_q;
                // char blink runs at half the cursor rate: flip on each cursor 1->0.
                if (cursor_q) char_d = ~char_q;
            end else begin
                frame_d = frame_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            ctrl_q   <= CTRL_RESET;
            conf_q   <= 2'b00;
            frame_q  <= '0;
            cursor_q <= 1'b0;
            char_q   <= 1'b0;
        end else begin
            ctrl_q   <= ctrl_d;
            conf_q   <= conf_d;
            frame_q  <= frame_d;
            cursor_q <= cursor_d;
            char_q   <= char_d;
        end
    end

    assign cursor_blink = cursor_q;
    assign char_blink   = char_q;

endmodule

// File: tb/tb_hgc_regfile.sv
// Directed bench for hgc_regfile: a Hercules instance and an MDA-only instance share the ISA pins.
// Stimulus pushes expected values into a scoreboard queue; a negedge monitor pops and compares.
// Pulse outputs are counted by free-running observers so held-strobe behaviour can be checked.
module tb_hgc_regfile;

    localparam int S = 2;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_l = 1'b0;
    logic [19:0] bus_a = 20'h0;
    logic        bus_aen = 1'b0;
    logic        bus_ior_l = 1'b1, bus_iow_l = 1'b1, bus_memr_l = 1'b1, bus_memw_l = 1'b1;
    logic [7:0]  bus_d = 8'h0, crtc_rdata = 8'h0, vram_rdata = 8'h0;
    logic        hsync_in = 1'b1, vsync_l_in = 1'b1, video_in = 1'b0;
    logic        lpen_in = 1'b0, lpen_sw = 1'b0;

    // h_* : Hercules instance, m_* : MDA-only instance
    logic [7:0] h_bus_out, m_bus_out;
    logic h_bus_dir, h_crtc_cs, h_crtc_wr, h_crtc_rd, h_mem_cs, h_mem_wr, h_mem_rd, h_lpen_strobe;
    logic h_grph_mode, h_grph_page, h_video_en, h_blink_en, h_cursor, h_char;
    logic m_bus_dir, m_crtc_cs, m_crtc_wr, m_crtc_rd, m_mem_cs, m_mem_wr, m_mem_rd, m_lpen_strobe;
    logic m_grph_mode, m_grph_page, m_video_en, m_blink_en, m_cursor, m_char;

    hgc_regfile #(.SYNC_STAGES(S)) u_hgc (
        .clk(clk), .reset_l(reset_l), .bus_a(bus_a), .bus_aen(bus_aen),
        .bus_ior_l(bus_ior_l), .bus_iow_l(bus_iow_l), .bus_memr_l(bus_memr_l),
        .bus_memw_l(bus_memw_l), .bus_d(bus_d), .bus_out(h_bus_out), .bus_dir(h_bus_dir),
        .crtc_rdata(crtc_rdata), .vram_rdata(vram_rdata), .crtc_cs(h_crtc_cs),
        .crtc_wr(h_crtc_wr), .crtc_rd(h_crtc_rd), .mem_cs(h_mem_cs), .mem_wr(h_mem_wr),
        .mem_rd(h_mem_rd), .hsync_in(hsync_in), .vsync_l_in(vsync_l_in), .video_in(video_in),
        .lpen_in(lpen_in), .lpen_sw(lpen_sw), .lpen_strobe(h_lpen_strobe),
        .grph_mode(h_grph_mode), .grph_page(h_grph_page), .video_enabled(h_video_en),
        .blink_enabled(h_blink_en), .cursor_blink(h_cursor), .char_blink(h_char));

    hgc_regfile #(.SYNC_STAGES(S), .HGC_EN(1'b0)) u_mda (
        .clk(clk), .reset_l(reset_l), .bus_a(bus_a), .bus_aen(bus_aen),
        .bus_ior_l(bus_ior_l), .bus_iow_l(bus_iow_l), .bus_memr_l(bus_memr_l),
        .bus_memw_l(bus_memw_l), .bus_d(bus_d), .bus_out(m_bus_out), .bus_dir(m_bus_dir),
        .crtc_rdata(crtc_rdata), .vram_rdata(vram_rdata), .crtc_cs(m_crtc_cs),
        .crtc_wr(m_crtc_wr), .crtc_rd(m_crtc_rd), .mem_cs(m_mem_cs), .mem_wr(m_mem_wr),
        .mem_rd(m_mem_rd), .hsync_in(hsync_in), .vsync_l_in(vsync_l_in), .video_in(video_in),
        .lpen_in(lpen_in), .lpen_sw(lpen_sw), .lpen_strobe(m_lpen_strobe),
        .grph_mode(m_grph_mode), .grph_page(m_grph_page), .video_enabled(m_video_en),
        .blink_enabled(m_blink_en), .cursor_blink(m_cursor), .char_blink(m_char));

    // ---------------- pulse / toggle observers ----------------
    logic cnt_en = 1'b0;
    int   crtc_wr_cnt = 0, lps_cnt = 0, cur_tog = 0, chr_tog = 0;
    logic cur_prev = 1'b0, chr_prev = 1'b0;

    always @(negedge clk) begin
        if (cnt_en) begin
            if (h_crtc_wr)         crtc_wr_cnt++;
            if (h_lpen_strobe)     lps_cnt++;
            if (h_cursor !== cur_prev) cur_tog++;
            if (h_char !== chr_prev)   chr_tog++;
            cur_prev = h_cursor;
            chr_prev = h_char;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0, checks = 0;
    logic smp_vld = 1'b0;

    function automatic logic [31:0] obs(input int sel);
        case (sel)
            0:  obs = {23'd0, h_bus_dir, h_bus_out};
            1:  obs = {28'd0, h_grph_page, h_blink_en, h_video_en, h_grph_mode};
            2:  obs = {28'd0, m_grph_page, m_blink_en, m_video_en, m_grph_mode};
            3:  obs = {31'd0, h_mem_cs};
            4:  obs = {31'd0, m_mem_cs};
            5:  obs = crtc_wr_cnt;
            6:  obs = cur_tog;
            7:  obs = chr_tog;
            8:  obs = lps_cnt;
            9:  obs = {30'd0, h_cursor, h_char};
            10: obs = {23'd0, m_bus_dir, m_bus_out};
            default: obs = 32'hDEAD_BEEF;
        endcase
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (smp_vld) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_underflow: sample request with empty queue");
            end else begin
                e = sbq.pop_front();
                if (obs(e.sel) !== e.exp) begin
                    errors++;
                    $display("FAIL %s: got %0h, expected %0h", e.name, obs(e.sel), e.exp);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input int sel, input logic [31:0] exp);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = exp;
        sbq.push_back(e);
        smp_vld = 1'b1;
        @(posedge clk);
        #2;
        smp_vld = 1'b0;
    endtask

    task automatic wr(input logic [19:0] addr, input logic [7:0] data);
        bus_a = addr;
        bus_d = data;
        bus_iow_l = 1'b0;
        step(S + 3);
        bus_iow_l = 1'b1;
        step(3);
    endtask

    task automatic rd(input logic [19:0] addr, input string name, input logic [31:0] exp);
        bus_a = addr;
        bus_ior_l = 1'b0;
        chk(name, 0, exp);
        bus_ior_l = 1'b1;
        step(1);
    endtask

    task automatic vsync_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            vsync_l_in = 1'b0;
            step(3);
            vsync_l_in = 1'b1;
            step(3);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        step(3);
        reset_l = 1'b1;
        step(2);
        cnt_en = 1'b1;

        // reset state: ctrl 0x28 -> page0 blink1 video1 mode0
        chk("reset_ctrl_hgc", 1, 32'h6);
        chk("reset_ctrl_mda", 2, 32'h6);
        chk("reset_blink",    9, 32'h0);
        chk("reset_crtc_wr",  5, 32'd0);

        // status read and idle bus
        rd(20'h003BA, "stat_read", 32'h1F1);
        bus_a = 20'h003BA;
        chk("stat_idle", 0, 32'h000);

        // CTRL write with config locked masks the graphics bits
        wr(20'h003B8, 8'h82);
        chk("ctrl_locked", 1, 32'h0);

        // unlock config, then graphics mode + page 1
        wr(20'h003BF, 8'h03);
        wr(20'h003B8, 8'h82);
        chk("ctrl_unlocked_hgc", 1, 32'h9);
        chk("ctrl_mda_forced",   2, 32'h0);
        bus_a = 20'hB8000;
        chk("memcs_b8000_hgc", 3, 32'd1);
        chk("memcs_b8000_mda", 4, 32'd0);
        bus_a = 20'hB0000;
        chk("memcs_b0000_hgc", 3, 32'd0);
        chk("memcs_b0000_mda", 4, 32'd1);
        bus_a = 20'hB7FFF;
        chk("memcs_b7fff_mda", 4, 32'd1);

        // VRAM read has priority on the read mux
        bus_a = 20'hB8000;
        vram_rdata = 8'h5A;
        bus_memr_l = 1'b0;
        chk("vram_read", 0, 32'h15A);
        bus_memr_l = 1'b1;
        step(2);

        // CRTC data readback (odd) and index (even)
        crtc_rdata = 8'hA7;
        bus_a = 20'h003B5;
        bus_ior_l = 1'b0;
        chk("crtc_read_hgc", 0, 32'h1A7);
        chk("crtc_read_mda", 10, 32'h1A7);
        bus_ior_l = 1'b1;
        step(1);
        rd(20'h003B4, "crtc_even_read", 32'h100);

        // held iow on CRTC index: exactly one crtc_wr pulse
        chk("crtc_wr_before", 5, 32'd0);
        bus_a = 20'h003B4;
        bus_d = 8'h0E;
        bus_iow_l = 1'b0;
        step(50);
        bus_iow_l = 1'b1;
        step(3);
        chk("crtc_wr_held_once", 5, 32'd1);

        // write latency on CTRL: old value for S cycles, new value on cycle S+1
        bus_a = 20'h003B8;
        bus_d = 8'h28;
        bus_iow_l = 1'b0;
        step(1);
        for (int i = 0; i < S; i++) chk("ctrl_latency_old", 1, 32'h9);
        chk("ctrl_latency_new", 1, 32'h6);
        step(40);
        bus_iow_l = 1'b1;
        step(3);
        chk("ctrl_held_stable", 1, 32'h6);

        // aen blocks I/O decode
        bus_aen = 1'b1;
        wr(20'h003B8, 8'h82);
        bus_aen = 1'b0;
        chk("aen_blocks_write", 1, 32'h6);

        // blink: 8 frames per cursor toggle, char at half rate
        vsync_pulses(8);
        chk("blink_after_8", 9, 32'h2);
        vsync_pulses(8);
        chk("blink_after_16", 9, 32'h1);
        vsync_pulses(16);
        chk("blink_after_32", 9, 32'h0);
        chk("cursor_toggles", 6, 32'd4);
        chk("char_toggles",   7, 32'd2);
        step(20);
        chk("blink_frozen", 9, 32'h0);

        // light pen
        lpen_in = 1'b1;
        step(S + 4);
`ifdef LIGHTPEN_EN
        chk("lpen_first_strobe", 8, 32'd1);
        rd(20'h003BA, "lpen_latched_stat", 32'h1F3);
        lpen_in = 1'b0;
        step(4);
        lpen_in = 1'b1;
        step(S + 4);
        chk("lpen_second_nostrobe", 8, 32'd1);
        wr(20'h003BB, 8'h00);
        rd(20'h003BA, "lpen_cleared_stat", 32'h1F1);
        wr(20'h003B9, 8'h00);
        rd(20'h003BA, "lpen_set_stat", 32'h1F3);
        chk("lpen_set_nostrobe", 8, 32'd1);
`else
        chk("lpen_disabled_strobe", 8, 32'd0);
        wr(20'h003B9, 8'h00);
        rd(20'h003BA, "lpen_disabled_stat", 32'h1F1);
`endif
        lpen_in = 1'b0;
        step(4);

        for (int i = 0; i < 10 && sbq.size() != 0; i++) step(1);
        if (sbq.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sbq.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
